// File: rtl/comp_pkg.sv
// Shared defaults and lane-packing helpers for the comp_pipe comparator.
package comp_pkg;

    localparam int DEF_DATAWIDTH = 16;
    localparam int DEF_LANES     = 4;
    localparam int DEF_CNTWIDTH  = 16;
    localparam int DEF_BUSWIDTH  = DEF_LANES * DEF_DATAWIDTH;

    // Largest value eq_count can hold before it sticks.
    localparam logic [DEF_CNTWIDTH-1:0] DEF_EQ_SAT = {DEF_CNTWIDTH{1'b1}};

    // Lane i occupies bus bits [lane_lsb(i) +: width].
    function automatic int lane_lsb(input int lane, input int width);
        return lane * width;
    endfunction

endpackage

// File: rtl/comp_lane.sv
// Combinational single-lane magnitude compare, signed or unsigned per mode.
module comp_lane #(
    parameter int DATAWIDTH = 16
) (
    input  logic [DATAWIDTH-1:0] a,
    input  logic [DATAWIDTH-1:0] b,
    input  logic                 signed_mode,
    output logic                 gt,
    output logic                 lt,
    output logic                 eq
);

    // One extra bit lets a single signed compare serve both modes:
    // sign-extend in signed mode, zero-extend in unsigned mode.
    logic signed [DATAWIDTH:0] a_x;
    logic signed [DATAWIDTH:0] b_x;

    assign a_x = {signed_mode & a[DATAWIDTH-1], a};
    assign b_x = {signed_mode & b[DATAWIDTH-1], b};

    assign gt = (a_x > b_x);
    assign lt = (a_x < b_x);
    assign eq = (a_x == b_x);

endmodule

// File: rtl/comp_pipe.sv
// Two-stage multi-lane comparator with valid/ready flow control and a
// saturating counter of delivered all-lanes-equal results.
module comp_pipe
    import comp_pkg::*;
#(
    parameter int DATAWIDTH = DEF_DATAWIDTH,
    parameter int LANES     = DEF_LANES,
    parameter int CNTWIDTH  = DEF_CNTWIDTH
) (
    input  logic                       Clk,
    input  logic                       Rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [LANES*DATAWIDTH-1:0] a,
    input  logic [LANES*DATAWIDTH-1:0] b,
    input  logic                       signed_mode,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [LANES-1:0]           gt,
    output logic [LANES-1:0]           lt,
    output logic [LANES-1:0]           eq,
    output logic                       all_eq,
    output logic                       any_gt,
    input  logic                       clr_cnt,
    output logic [CNTWIDTH-1:0]        eq_count
);

    localparam logic [CNTWIDTH-1:0] EQ_SAT = {CNTWIDTH{1'b1}};

    logic                       s1_en;
    logic                       s2_en;

    logic                       vld_p1;
    logic [LANES*DATAWIDTH-1:0] a_p1;
    logic [LANES*DATAWIDTH-1:0] b_p1;
    logic                       smode_p1;

    logic [LANES-1:0]           gt_c;
    logic [LANES-1:0]           lt_c;
    logic [LANES-1:0]           eq_c;

    logic                       vld_p2;
    logic [LANES-1:0]           gt_p2;
    logic [LANES-1:0]           lt_p2;
    logic [LANES-1:0]           eq_p2;
    logic                       all_eq_p2;
    logic                       any_gt_p2;

    logic [CNTWIDTH-1:0]        cnt;

    function automatic logic [CNTWIDTH-1:0] sat_inc(input logic [CNTWIDTH-1:0] v);
        return (v == EQ_SAT) ? v : v + CNTWIDTH'(1);
    endfunction

    // A stage may load when the stage after it will be free this edge.
    assign s2_en    = !vld_p2 || out_ready;
    assign s1_en    = s2_en || !vld_p1;
    assign in_ready = s1_en;

    // ---- stage 1: capture transaction ----
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            vld_p1 <= 1'b0;
        end else if (s1_en) begin
            vld_p1 <= in_valid;
        end
    end

    always_ff @(posedge Clk) begin
        if (s1_en && in_valid) begin
            a_p1     <= a;
            b_p1     <= b;
            smode_p1 <= signed_mode;
        end
    end

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        comp_lane #(
            .DATAWIDTH(DATAWIDTH)
        ) u_lane (
            .a          (a_p1[lane_lsb(i, DATAWIDTH) +: DATAWIDTH]),
            .b          (b_p1[lane_lsb(i, DATAWIDTH) +: DATAWIDTH]),
            .signed_mode(smode_p1),
            .gt         (gt_c[i]),
            .lt         (lt_c[i]),
            .eq         (eq_c[i])
        );
    end

    // ---- stage 2: register compare results ----
    // Bubbles load all-zero flags so idle outputs stay clean.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            vld_p2    <= 1'b0;
            gt_p2     <= '0;
            lt_p2     <= '0;
            eq_p2     <= '0;
            all_eq_p2 <= 1'b0;
            any_gt_p2 <= 1'b0;
        end else if (s2_en) begin
            vld_p2    <= vld_p1;
            gt_p2     <= vld_p1 ? gt_c : '0;
            lt_p2     <= vld_p1 ? lt_c : '0;
            eq_p2     <= vld_p1 ? eq_c : '0;
            all_eq_p2 <= vld_p1 && (&eq_c);
            any_gt_p2 <= vld_p1 && (|gt_c);
        end
    end

    // Clear has priority over a coincident increment.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            cnt <= '0;
        end else if (clr_cnt) begin
            cnt <= '0;
        end else if (vld_p2 && out_ready && all_eq_p2) begin
            cnt <= sat_inc(cnt);
        end
    end

    assign out_valid = vld_p2;
    assign gt        = gt_p2;
    assign lt        = lt_p2;
    assign eq        = eq_p2;
    assign all_eq    = all_eq_p2;
    assign any_gt    = any_gt_p2;
    assign eq_count  = cnt;

endmodule

// File: tb/tb_comp_pipe.sv
// Bench for comp_pipe: directed vector table, stall/reset sequences and
// randomized traffic checked against a transaction-level reference model.
module tb_comp_pipe;

    localparam int DW  = 16;
    localparam int L   = 4;
    localparam int CW  = 4;
    localparam int BW  = DW * L;
    localparam int SAT = 15;

    logic          Clk = 1'b0;
    logic          Rst;
    logic          in_valid;
    logic          in_ready;
    logic [BW-1:0] a;
    logic [BW-1:0] b;
    logic          signed_mode;
    logic          out_valid;
    logic          out_ready;
    logic [L-1:0]  gt;
    logic [L-1:0]  lt;
    logic [L-1:0]  eq;
    logic          all_eq;
    logic          any_gt;
    logic          clr_cnt;
    logic [CW-1:0] eq_count;

    always #5 Clk = ~Clk;

    comp_pipe #(
        .DATAWIDTH(DW),
        .LANES    (L),
        .CNTWIDTH (CW)
    ) dut (
        .Clk        (Clk),
        .Rst        (Rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .a          (a),
        .b          (b),
        .signed_mode(signed_mode),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .gt         (gt),
        .lt         (lt),
        .eq         (eq),
        .all_eq     (all_eq),
        .any_gt     (any_gt),
        .clr_cnt    (clr_cnt),
        .eq_count   (eq_count)
    );

    typedef struct {
        logic [BW-1:0] a;
        logic [BW-1:0] b;
        logic          mode;
        logic [L-1:0]  gt;
        logic [L-1:0]  lt;
        logic [L-1:0]  eq;
        logic          all_eq;
        logic          any_gt;
    } vec_t;

    typedef struct {
        logic [13:0] flags;
        int          acc;
    } exp_t;

    int          n_chk = 0;
    int          n_pass = 0;
    exp_t        q[$];
    int          cyc = 0;
    int          last_deliv = -10;
    int          n_deliv = 0;
    int          cnt_m = 0;
    logic [15:0] corners[4] = '{16'h0000, 16'h7FFF, 16'h8000, 16'hFFFF};
    vec_t        tbl[6];

    function automatic void chk(string nm, logic [31:0] got, logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, got, exp, cyc);
    endfunction

    // Reference compare: each lane read as an integer in the chosen mode.
    function automatic logic [13:0] ref_cmp(logic [BW-1:0] aa, logic [BW-1:0] bb, logic m);
        logic [L-1:0] g, l, e;
        int x, y;
        for (int i = 0; i < L; i++) begin
            x = m ? int'($signed(aa[i*DW +: DW])) : int'(aa[i*DW +: DW]);
            y = m ? int'($signed(bb[i*DW +: DW])) : int'(bb[i*DW +: DW]);
            g[i] = (x > y);
            l[i] = (x < y);
            e[i] = (x == y);
        end
        return {g, l, e, &e, |g};
    endfunction

    task automatic rand_inputs();
        for (int i = 0; i < L; i++) begin
            logic [15:0] x, y;
            int k;
            k = $urandom_range(0, 7);
            x = 16'($urandom);
            y = 16'($urandom);
            if (k < 3) y = x;
            else if (k == 3) begin
                x = corners[$urandom_range(0, 3)];
                y = corners[$urandom_range(0, 3)];
            end
            a[i*DW +: DW] = x;
            b[i*DW +: DW] = y;
        end
        signed_mode = 1'($urandom_range(0, 1));
    endtask

    // One clock: entered at a falling edge with inputs set, returns at the next.
    task automatic cycle(output bit acc);
        bit   exp_ov;
        bit   exp_ir;
        bit   deliver;
        int   rdy;
        exp_t h;
        #1;
        exp_ov = 1'b0;
        if (q.size() > 0) begin
            rdy = (q[0].acc + 2 > last_deliv + 1) ? q[0].acc + 2 : last_deliv + 1;
            exp_ov = (cyc >= rdy);
        end
        exp_ir = !(q.size() >= 2 && !out_ready);
        chk("out_valid", 32'(out_valid), 32'(exp_ov));
        chk("in_ready", 32'(in_ready), 32'(exp_ir));
        chk("eq_count", 32'(eq_count), 32'(cnt_m));
        if (exp_ov)
            chk("result", 32'({gt, lt, eq, all_eq, any_gt}), 32'(q[0].flags));
        deliver = exp_ov && out_ready;
        acc = in_valid && exp_ir;
        if (deliver) begin
            h = q.pop_front();
            last_deliv = cyc;
            n_deliv++;
        end
        if (clr_cnt) cnt_m = 0;
        else if (deliver && h.flags[1]) cnt_m = (cnt_m >= SAT) ? SAT : cnt_m + 1;
        if (acc) q.push_back('{flags: ref_cmp(a, b, signed_mode), acc: cyc});
        cyc++;
        @(negedge Clk);
    endtask

    task automatic drain();
        bit acc;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        clr_cnt   = 1'b0;
        repeat (4) cycle(acc);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        bit acc;
        int sent;
        int d0;
        int s;
        int sent_at_release;

        tbl[0] = '{{4{16'hFFFF}}, {4{16'h0001}}, 1'b0, 4'hF, 4'h0, 4'h0, 1'b0, 1'b1};
        tbl[1] = '{{4{16'hFFFF}}, {4{16'h0001}}, 1'b1, 4'h0, 4'hF, 4'h0, 1'b0, 1'b0};
        tbl[2] = '{{4{16'h8000}}, {4{16'h8000}}, 1'b1, 4'h0, 4'h0, 4'hF, 1'b1, 1'b0};
        tbl[3] = '{{16'h0005, 16'h8000, 16'h7FFF, 16'h1234},
                   {16'h0005, 16'h7FFF, 16'h8000, 16'h1235},
                   1'b0, 4'b0100, 4'b0011, 4'b1000, 1'b0, 1'b1};
        tbl[4] = '{{16'h0005, 16'h8000, 16'h7FFF, 16'h1234},
                   {16'h0005, 16'h7FFF, 16'h8000, 16'h1235},
                   1'b1, 4'b0010, 4'b0101, 4'b1000, 1'b0, 1'b1};
        tbl[5] = '{{4{16'h0000}}, {4{16'hFFFF}}, 1'b0, 4'h0, 4'hF, 4'h0, 1'b0, 1'b0};

        // Reset held with live-looking inputs
        Rst = 1'b0;
        in_valid = 1'b1;
        out_ready = 1'b0;
        clr_cnt = 1'b0;
        rand_inputs();
        repeat (3) @(negedge Clk);
        #1;
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_flags", 32'({gt, lt, eq, all_eq, any_gt}), 0);
        chk("rst_eq_count", 32'(eq_count), 0);
        Rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b1;
        #1;
        chk("rst_in_ready", 32'(in_ready), 1);
        @(negedge Clk);

        // Directed vector table
        for (int i = 0; i < 6; i++) begin
            a = tbl[i].a;
            b = tbl[i].b;
            signed_mode = tbl[i].mode;
            in_valid = 1'b1;
            cycle(acc);
            chk($sformatf("tbl%0d_accept", i), 32'(acc), 1);
            in_valid = 1'b0;
            cycle(acc);
            chk($sformatf("tbl%0d_out_valid", i), 32'(out_valid), 1);
            chk($sformatf("tbl%0d_flags", i), 32'({gt, lt, eq, all_eq, any_gt}),
                32'({tbl[i].gt, tbl[i].lt, tbl[i].eq, tbl[i].all_eq, tbl[i].any_gt}));
        end
        drain();

        // Backpressure: consumer stalls for the first five cycles
        sent = 0;
        sent_at_release = -1;
        d0 = n_deliv;
        rand_inputs();
        for (int i = 0; i < 30 && (sent < 4 || q.size() > 0); i++) begin
            out_ready = (i >= 5);
            if (i == 5) sent_at_release = sent;
            in_valid = (sent < 4);
            cycle(acc);
            if (acc) begin
                sent++;
                rand_inputs();
            end
        end
        chk("bp_accepted_while_stalled", 32'(sent_at_release), 2);
        chk("bp_delivered", 32'(n_deliv - d0), 4);
        drain();

        // Back-to-back throughput
        sent = 0;
        d0 = n_deliv;
        s = cyc;
        out_ready = 1'b1;
        for (int i = 0; i < 300 && (n_deliv - d0) < 100; i++) begin
            in_valid = (sent < 100);
            rand_inputs();
            cycle(acc);
            if (acc) sent++;
        end
        chk("tp_delivered", 32'(n_deliv - d0), 100);
        chk("tp_last_cycle", 32'(last_deliv - s), 101);
        drain();

        // Counter saturation and clear-over-increment
        clr_cnt = 1'b1;
        cycle(acc);
        clr_cnt = 1'b0;
        chk("cnt_cleared", 32'(eq_count), 0);
        sent = 0;
        for (int i = 0; i < 100 && sent < 20; i++) begin
            rand_inputs();
            b = a;
            in_valid = 1'b1;
            cycle(acc);
            if (acc) sent++;
        end
        drain();
        chk("cnt_saturated", 32'(eq_count), SAT);
        rand_inputs();
        b = a;
        in_valid = 1'b1;
        cycle(acc);
        in_valid = 1'b0;
        cycle(acc);
        chk("cnt_coinc_out_valid", 32'(out_valid), 1);
        clr_cnt = 1'b1;
        cycle(acc);
        clr_cnt = 1'b0;
        chk("cnt_clear_wins", 32'(eq_count), 0);
        drain();

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            rand_inputs();
            in_valid  = 1'($urandom_range(0, 1));
            out_ready = ($urandom_range(0, 3) != 0);
            clr_cnt   = ($urandom_range(0, 31) == 0);
            cycle(acc);
        end
        drain();

        // Reset while the pipeline is full
        out_ready = 1'b0;
        in_valid = 1'b1;
        rand_inputs();
        b = a;
        cycle(acc);
        rand_inputs();
        cycle(acc);
        in_valid = 1'b0;
        #1;
        chk("mr_full_in_ready", 32'(in_ready), 0);
        chk("mr_full_out_valid", 32'(out_valid), 1);
        #1;
        Rst = 1'b0;
        #1;
        chk("mr_out_valid", 32'(out_valid), 0);
        chk("mr_flags", 32'({gt, lt, eq, all_eq, any_gt}), 0);
        chk("mr_eq_count", 32'(eq_count), 0);
        Rst = 1'b1;
        q.delete();
        cnt_m = 0;
        out_ready = 1'b1;
        @(negedge Clk);
        repeat (5) cycle(acc);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/comp_pipe.md
# comp_pipe

Pipelined, multi-lane magnitude comparator with a valid/ready stream interface, per-transaction signed/unsigned mode and a saturating all-lanes-equal counter. It compares LANES independent a/b pairs per transaction and drives one-hot gt/lt/eq flags per lane plus aggregate flags. It sits between datapath producers and control logic that consumes compare results under backpressure.

## Interface
- DATAWIDTH, 16, bit width of each lane operand
- LANES, 4, number of independent compare lanes (≥1)
- CNTWIDTH, 16, width of eq_count
- Clk  input  1  clock; all state on rising edge
- Rst  input  1  asynchronous, active-low reset
- in_valid  input  1  a, b, signed_mode valid this cycle
- in_ready  output  1  block accepts a transaction this cycle
- a  input  LANES*DATAWIDTH  lane operands; lane i = a[i*DATAWIDTH +: DATAWIDTH]
- b  input  LANES*DATAWIDTH  lane operands, same packing
- signed_mode  input  1  1: two's-complement compare; 0: unsigned; captured with the transaction
- out_valid  output  1  result registers hold a valid result
- out_ready  input  1  consumer accepts result
- gt, lt, eq  output  LANES each  per-lane flags, exactly one set per lane when out_valid
- all_eq  output  1  AND of eq over all lanes
- any_gt  output  1  OR of gt over all lanes
- clr_cnt  input  1  synchronous clear of eq_count
- eq_count  output  CNTWIDTH  saturating count of delivered results with all_eq=1

## Operation
- Two register stages. S1: capture a, b, signed_mode, valid bit. S2: lane compare of S1 contents, register gt/lt/eq/all_eq/any_gt and out_valid.
- Per lane: a<b → lt=1; a>b → gt=1; else eq=1; comparison interpreted per captured signed_mode.
- Advance rules: s2_en = !out_valid | out_ready; s1_en = s2_en | !s1_valid; in_ready = s1_en (combinational from out_ready and state).
- Input transfer: in_valid & in_ready. Output transfer: out_valid & out_ready.
- Occupancy states: EMPTY (no valid stage), ONE (S1 or S2 valid), FULL (both valid). FULL with out_ready=0 → in_ready=0; every other case in_ready=1.
- While out_valid & !out_ready, all outputs held bit-stable.
- eq_count: +1 on output transfer with all_eq=1; saturates at 2^CNTWIDTH−1 (no wrap).
- clr_cnt=1: eq_count←0 next edge; clear wins over a coincident increment (increment lost).
- Rst low (any time, including mid-stream): all stage valid bits, gt, lt, eq, all_eq, any_gt, out_valid, eq_count ← 0 immediately; in-flight transactions dropped. in_ready is 1 while in reset-free EMPTY state.

## Timing
- Latency: transaction accepted at edge N → out_valid at edge N+2 with no backpressure.
- Throughput: one transaction per cycle with out_ready held 1.
- Simultaneous input and output transfer in FULL: both pipeline stages shift; no bubble, no loss.
- Reset deassertion synchronous to Clk externally; first acceptance possible on the first edge after release.
- eq_count update visible the cycle after the output transfer.

## Structure
- Package comp_pkg: lane packing helper constants, default parameter values, and a localparam for eq_count saturation value derived from CNTWIDTH.
- Sub-module comp_lane: combinational single-lane compare (a, b, signed_mode → gt, lt, eq), instantiated LANES times via generate in comp_pipe.

## Test plan
- Reset: hold Rst=0 with random inputs → out_valid=0, gt=lt=eq=0, eq_count=0, in_ready=1 after release.
- Unsigned/signed: DATAWIDTH=16, a=16'hFFFF, b=16'h0001; signed_mode=0 → gt=1; signed_mode=1 → lt=1; a=b=16'h8000 → eq=1, all_eq=1 (all lanes equal).
- Backpressure: stream 4 transactions, out_ready=0 for 5 cycles → in_ready=0 after 2 accepted, outputs stable; release → remaining results delivered in order, none lost or duplicated.
- Throughput: 100 back-to-back transactions, out_ready=1 → first result 2 cycles after first accept, then one per cycle.
- Counter: CNTWIDTH=4, deliver 20 all-equal results → eq_count saturates at 15; assert clr_cnt coincident with an all-equal delivery → eq_count=0.
- Reset mid-operation: FULL pipeline, pulse Rst low between edges → out_valid drops immediately, no stale result appears after release.
